alu_sequencer: RTL and testbench

- Micro-sequencer in front of alu_registers.
- Accepts 16-bit instruction words over a valid/ready handshake, decodes them, and drives alu_registers' addr_a/addr_b/addr_r/data_in/op for exactly one issue cycle.
- Stalls for the ALU latency, then returns read data to the requester.
- Replaces hand-timed testbench stimulus and serves as the execute stage of the future core.

---
 rtl/alu_sequencer_pkg.sv | 47 ++++
 rtl/alu_registers.sv | 36 +++
 rtl/alu_seq_decode.sv | 21 ++
 rtl/alu_sequencer.sv | 149 ++++++++++++++
 tb/tb_alu_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared types and instruction-word field positions for the ALU micro-sequencer
// and the register file it drives.
package alu_sequencer_pkg;

  typedef enum logic [1:0] {
    NOP       = 2'b00,
    REG_WRITE = 2'b01,
    REG_READ  = 2'b10,
    ADD       = 2'b11
  } ALUOp;

  typedef enum logic [1:0] {
    SEQ_NOP   = 2'b00,
    SEQ_WRITE = 2'b01,
    SEQ_READ  = 2'b10,
    SEQ_ADD   = 2'b11
  } SeqOpcode;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } SeqState;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 14;
  localparam int RA_MSB  = 13;
  localparam int RA_LSB  = 11;
  localparam int RB_MSB  = 10;
  localparam int RB_LSB  = 8;
  localparam int RR_MSB  = 7;
  localparam int RR_LSB  = 5;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  function automatic ALUOp seq_to_alu_op(input SeqOpcode opc);
    ALUOp result;
    case (opc)
      SEQ_WRITE: result = REG_WRITE;
      SEQ_READ:  result = REG_READ;
      SEQ_ADD:   result = ADD;
      default:   result = NOP;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/alu_registers.sv
// Eight 8-bit registers with write, registered read and 8-bit wrap-around add;
// the execution unit the sequencer drives.
module alu_registers
  import alu_sequencer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] addr_a,
  input  logic [2:0] addr_b,
  input  logic [2:0] addr_r,
  input  logic [7:0] data_in,
  input  ALUOp       op,
  output logic [7:0] data_out
);

  logic [7:0] regs_q [8];
  logic [7:0] data_out_q;

  // data_out only moves on a read, so it stays stable while the sequencer waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= 8'd0;
      data_out_q <= 8'd0;
    end else begin
      case (op)
        REG_WRITE: regs_q[addr_a] <= data_in;
        REG_READ:  data_out_q     <= regs_q[addr_a];
        ADD:       regs_q[addr_r] <= regs_q[addr_a] + regs_q[addr_b];
        default:   ;
      endcase
    end
  end

  assign data_out = data_out_q;

endmodule

// File: rtl/alu_seq_decode.sv
// Combinational instruction decoder: splits a 16-bit instruction word into
// opcode, source registers, destination register and immediate.
module alu_seq_decode
  import alu_sequencer_pkg::*;
(
  input  logic [15:0] instr_i,
  output SeqOpcode    op_o,
  output logic [2:0]  ra_o,
  output logic [2:0]  rb_o,
  output logic [2:0]  rr_o,
  output logic [7:0]  imm_o
);

  assign op_o  = SeqOpcode'(instr_i[OPC_MSB:OPC_LSB]);
  assign ra_o  = instr_i[RA_MSB:RA_LSB];
  assign rb_o  = instr_i[RB_MSB:RB_LSB];
  // WRITE and READ name their register in the upper field; only ADD has a separate destination.
  assign rr_o  = (op_o == SEQ_ADD) ? instr_i[RR_MSB:RR_LSB] : instr_i[RA_MSB:RA_LSB];
  assign imm_o = instr_i[IMM_MSB:IMM_LSB];

endmodule

// File: rtl/alu_sequencer.sv
// Micro-sequencer that issues decoded instructions to alu_registers one at a time.
// Define ALU_SEQ_RETIRE_COUNT_EN to build the retired-instruction counter.
module alu_sequencer
  import alu_sequencer_pkg::*;
#(
  parameter int ADD_LATENCY  = 2,
  parameter int READ_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  output logic [2:0]  alu_addr_a,
  output logic [2:0]  alu_addr_b,
  output logic [2:0]  alu_addr_r,
  output logic [7:0]  alu_data_in,
  output ALUOp        alu_op,
  input  logic [7:0]  alu_data_out,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  output logic [2:0]  rd_reg,
  output logic        busy,
  output logic [15:0] retired_count
);

  SeqOpcode   dec_op;
  logic [2:0] dec_ra;
  logic [2:0] dec_rb;
  logic [2:0] dec_rr;
  logic [7:0] dec_imm;

  alu_seq_decode u_decode (
    .instr_i (instr),
    .op_o    (dec_op),
    .ra_o    (dec_ra),
    .rb_o    (dec_rb),
    .rr_o    (dec_rr),
    .imm_o   (dec_imm)
  );

  SeqState    state_q;
  SeqOpcode   opc_q;
  logic [3:0] cnt_q;
  ALUOp       alu_op_q;
  logic [2:0] alu_addr_a_q;
  logic [2:0] alu_addr_b_q;
  logic [2:0] alu_addr_r_q;
  logic [7:0] alu_data_in_q;
  logic       rd_valid_q;
  logic [7:0] rd_data_q;
  logic [2:0] rd_reg_q;
  logic       accept;

  assign accept = instr_valid && (state_q == IDLE);

  // The ALU-facing registers double as the operand store: they are loaded at accept
  // and simply hold through WAIT so the register file sees stable addresses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      opc_q         <= SEQ_NOP;
      cnt_q         <= 4'd0;
      alu_op_q      <= NOP;
      alu_addr_a_q  <= 3'd0;
      alu_addr_b_q  <= 3'd0;
      alu_addr_r_q  <= 3'd0;
      alu_data_in_q <= 8'd0;
      rd_valid_q    <= 1'b0;
      rd_data_q     <= 8'd0;
      rd_reg_q      <= 3'd0;
    end else begin
      rd_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept && dec_op != SEQ_NOP) begin
            state_q       <= ISSUE;
            opc_q         <= dec_op;
            alu_op_q      <= seq_to_alu_op(dec_op);
            alu_addr_a_q  <= dec_ra;
            alu_addr_b_q  <= (dec_op == SEQ_ADD) ? dec_rb : 3'd0;
            alu_addr_r_q  <= (dec_op == SEQ_ADD) ? dec_rr : 3'd0;
            alu_data_in_q <= (dec_op == SEQ_WRITE) ? dec_imm : 8'd0;
          end
        end
        ISSUE: begin
          alu_op_q <= NOP;
          case (opc_q)
            SEQ_READ: begin
              state_q <= WAIT;
              cnt_q   <= 4'(READ_LATENCY);
            end
            SEQ_ADD: begin
              state_q <= WAIT;
              cnt_q   <= 4'(ADD_LATENCY);
            end
            default: state_q <= IDLE;
          endcase
        end
        WAIT: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_q <= IDLE;
            if (opc_q == SEQ_READ) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= alu_data_out;
              rd_reg_q   <= alu_addr_a_q;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign instr_ready = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign alu_op      = alu_op_q;
  assign alu_addr_a  = alu_addr_a_q;
  assign alu_addr_b  = alu_addr_b_q;
  assign alu_addr_r  = alu_addr_r_q;
  assign alu_data_in = alu_data_in_q;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_reg      = rd_reg_q;

`ifdef ALU_SEQ_RETIRE_COUNT_EN
  logic        retire;
  logic [15:0] retired_q;

  // NOPs retire at accept, WRITEs at the end of ISSUE, READ/ADD when the wait expires.
  assign retire = (accept && dec_op == SEQ_NOP)
               || (state_q == ISSUE && opc_q == SEQ_WRITE)
               || (state_q == WAIT && cnt_q == 4'd1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      retired_q <= 16'd0;
    end else if (retire) begin
      retired_q <= retired_q + 16'd1;
    end
  end

  assign retired_count = retired_q;
`else
  assign retired_count = 16'd0;
`endif

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer driving alu_registers, with a register-file
// reference model and a monitor that collects read results.
module tb_alu_sequencer;
  import alu_sequencer_pkg::*;

  localparam int ADD_LAT  = 2;
  localparam int READ_LAT = 1;
  localparam int TIMEOUT  = 200;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic [15:0] instr = 16'd0;
  logic        instr_ready;
  logic [2:0]  alu_addr_a, alu_addr_b, alu_addr_r;
  logic [7:0]  alu_data_in, alu_data_out;
  ALUOp        alu_op;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic [2:0]  rd_reg;
  logic        busy;
  logic [15:0] retired_count;

  int          tests = 0;
  int          errors = 0;
  logic [7:0]  model_regs [8];
  int          model_retired = 0;
  logic [10:0] exp_q [$];
  logic [10:0] obs_q [$];
  time         accept_time;

  always #5 clk = ~clk;

  alu_sequencer #(.ADD_LATENCY(ADD_LAT), .READ_LATENCY(READ_LAT)) dut (
    .clk           (clk),
    .reset         (reset),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .alu_addr_a    (alu_addr_a),
    .alu_addr_b    (alu_addr_b),
    .alu_addr_r    (alu_addr_r),
    .alu_data_in   (alu_data_in),
    .alu_op        (alu_op),
    .alu_data_out  (alu_data_out),
    .rd_valid      (rd_valid),
    .rd_data       (rd_data),
    .rd_reg        (rd_reg),
    .busy          (busy),
    .retired_count (retired_count)
  );

  alu_registers u_regs (
    .clk      (clk),
    .rst_n    (reset),
    .addr_a   (alu_addr_a),
    .addr_b   (alu_addr_b),
    .addr_r   (alu_addr_r),
    .data_in  (alu_data_in),
    .op       (alu_op),
    .data_out (alu_data_out)
  );

  // Every read result the DUT presents, as {register, data}.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) obs_q.push_back({rd_reg, rd_data});
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [15:0] enc_write(input logic [2:0] r, input logic [7:0] v);
    return {2'b01, r, 3'b000, v};
  endfunction

  function automatic logic [15:0] enc_read(input logic [2:0] r);
    return {2'b10, r, 11'd0};
  endfunction

  function automatic logic [15:0] enc_add(input logic [2:0] a, input logic [2:0] b, input logic [2:0] r);
    return {2'b11, a, b, r, 5'd0};
  endfunction

  function automatic logic [15:0] expected_retired();
`ifdef ALU_SEQ_RETIRE_COUNT_EN
    return 16'(model_retired);
`else
    return 16'd0;
`endif
  endfunction

  // Architectural effect of one instruction on the register file.
  task automatic model_apply(input logic [15:0] w);
    logic [2:0] f1, f2, f3;
    f1 = w[13:11];
    f2 = w[10:8];
    f3 = w[7:5];
    case (w[15:14])
      2'b01:   model_regs[f1] = w[7:0];
      2'b10:   exp_q.push_back({f1, model_regs[f1]});
      2'b11:   model_regs[f3] = model_regs[f1] + model_regs[f2];
      default: ;
    endcase
    model_retired++;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = 8'd0;
    model_retired = 0;
  endtask

  // Offer an instruction from a negedge; returns at the negedge after acceptance.
  task automatic send(input logic [15:0] w);
    int g = 0;
    instr = w;
    instr_valid = 1'b1;
    while (instr_ready !== 1'b1 && g < TIMEOUT) begin
      @(negedge clk);
      g++;
    end
    if (g >= TIMEOUT) begin
      tests++;
      errors++;
      $display("[TB] FAIL send_timeout instr=%h ready=%b required 1", w, instr_ready);
      instr_valid = 1'b0;
      return;
    end
    @(posedge clk);
    accept_time = $time;
    @(negedge clk);
    instr_valid = 1'b0;
    instr = 16'($urandom);
    model_apply(w);
  endtask

  task automatic drain();
    int g = 0;
    @(negedge clk);
    while (instr_ready !== 1'b1 && g < TIMEOUT) begin
      @(negedge clk);
      g++;
    end
    if (g >= TIMEOUT) begin
      tests++;
      errors++;
      $display("[TB] FAIL drain_timeout ready=%b required 1", instr_ready);
    end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    tests++; if (instr_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready got=%b want=1", instr_ready); end
    tests++; if (alu_op !== NOP) begin errors++; $display("[TB] FAIL reset_op got=%0d want=%0d", alu_op, NOP); end
    tests++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_rd_valid got=%b want=0", rd_valid); end
    tests++; if (retired_count !== 16'd0) begin errors++; $display("[TB] FAIL reset_retired got=%h want=0000", retired_count); end
    tests++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy got=%b want=0", busy); end
    tests++; if ({alu_addr_a, alu_addr_b, alu_addr_r, alu_data_in, rd_data, rd_reg} !== 28'd0) begin
      errors++; $display("[TB] FAIL reset_outputs a=%0d b=%0d r=%0d din=%h rd=%h rreg=%0d want all 0",
                         alu_addr_a, alu_addr_b, alu_addr_r, alu_data_in, rd_data, rd_reg);
    end
  endtask

  task automatic test_basic();
    exp_q.delete(); obs_q.delete();
    send(enc_write(3'd0, 8'h42));
    send(enc_write(3'd1, 8'h24));
    send(enc_add(3'd0, 3'd1, 3'd2));
    send(enc_read(3'd2));
    send(enc_read(3'd0));
    drain();
    tests++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL basic_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL basic_read[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    tests++; if (obs_q.size() < 2 || obs_q[0] !== {3'd2, 8'h66} || obs_q[1] !== {3'd0, 8'h42}) begin
      errors++; $display("[TB] FAIL basic_const got=%h,%h want=%h,%h", obs_q[0], obs_q[1], {3'd2, 8'h66}, {3'd0, 8'h42});
    end
  endtask

  task automatic test_fibonacci();
    logic [7:0] fib [5];
    time t_prev;
    fib = '{8'h02, 8'h03, 8'h05, 8'h08, 8'h0d};
    exp_q.delete(); obs_q.delete();
    send(enc_write(3'd0, 8'd0));
    send(enc_write(3'd1, 8'd1));
    send(enc_write(3'd2, 8'd1));
    t_prev = 0;
    for (int r = 3; r < 8; r++) begin
      send(enc_add(3'(r - 2), 3'(r - 1), 3'(r)));
      if (r > 3) begin
        tests++; if (accept_time - t_prev != time'((2 + ADD_LAT) * 10)) begin
          errors++; $display("[TB] FAIL fib_add_spacing got=%0t want=%0d", accept_time - t_prev, (2 + ADD_LAT) * 10);
        end
      end
      t_prev = accept_time;
    end
    for (int r = 3; r < 8; r++) send(enc_read(3'(r)));
    drain();
    tests++; if (obs_q.size() != 5) begin errors++; $display("[TB] FAIL fib_count got=%0d want=5", obs_q.size()); end
    for (int i = 0; i < 5 && i < obs_q.size(); i++) begin
      tests++; if (obs_q[i] !== {3'(i + 3), fib[i]} || obs_q[i] !== exp_q[i]) begin
        errors++; $display("[TB] FAIL fib_read[%0d] got=%h want=%h", i, obs_q[i], {3'(i + 3), fib[i]});
      end
    end
  endtask

  task automatic test_timing();
    int  low, op_cnt, g;
    time t0;
    exp_q.delete(); obs_q.delete();
    send(enc_write(3'd5, 8'h9c));
    tests++; if (alu_op !== REG_WRITE || alu_addr_a !== 3'd5 || alu_data_in !== 8'h9c) begin
      errors++; $display("[TB] FAIL write_issue op=%0d a=%0d din=%h want op=%0d a=5 din=9c", alu_op, alu_addr_a, alu_data_in, REG_WRITE);
    end
    t0 = accept_time;
    send(enc_write(3'd6, 8'h11));
    tests++; if (accept_time - t0 != 20) begin errors++; $display("[TB] FAIL write_spacing got=%0t want=20", accept_time - t0); end

    send(enc_add(3'd5, 3'd6, 3'd4));
    tests++; if (alu_addr_a !== 3'd5 || alu_addr_b !== 3'd6 || alu_addr_r !== 3'd4) begin
      errors++; $display("[TB] FAIL add_issue a=%0d b=%0d r=%0d want 5,6,4", alu_addr_a, alu_addr_b, alu_addr_r);
    end
    low = 0; op_cnt = 0; g = 0;
    while (instr_ready !== 1'b1 && g < TIMEOUT) begin
      if (alu_op === ADD) op_cnt++;
      low++;
      @(negedge clk);
      g++;
    end
    tests++; if (low != 1 + ADD_LAT) begin errors++; $display("[TB] FAIL add_ready_low got=%0d want=%0d", low, 1 + ADD_LAT); end
    tests++; if (op_cnt != 1 || alu_op !== NOP) begin errors++; $display("[TB] FAIL add_op_cycles got=%0d op_after=%0d want 1,NOP", op_cnt, alu_op); end

    send(enc_read(3'd4));
    low = 0; g = 0;
    while (instr_ready !== 1'b1 && g < TIMEOUT) begin
      low++;
      @(negedge clk);
      g++;
    end
    tests++; if (low != 1 + READ_LAT) begin errors++; $display("[TB] FAIL read_ready_low got=%0d want=%0d", low, 1 + READ_LAT); end
    tests++; if (rd_valid !== 1'b1 || rd_reg !== 3'd4 || rd_data !== 8'had) begin
      errors++; $display("[TB] FAIL read_pulse valid=%b reg=%0d data=%h want 1,4,ad", rd_valid, rd_reg, rd_data);
    end
    @(negedge clk);
    tests++; if (rd_valid !== 1'b0) begin errors++; $display("[TB] FAIL read_pulse_width got=%b want=0", rd_valid); end
  endtask

  task automatic test_wrap();
    exp_q.delete(); obs_q.delete();
    send(enc_write(3'd0, 8'hf0));
    send(enc_write(3'd1, 8'h20));
    send(enc_add(3'd0, 3'd1, 3'd2));
    send(enc_read(3'd2));
    drain();
    tests++; if (obs_q.size() != 1 || obs_q[0] !== {3'd2, 8'h10} || obs_q[0] !== exp_q[0]) begin
      errors++; $display("[TB] FAIL wrap_read count=%0d got=%h want=%h", obs_q.size(), obs_q[0], {3'd2, 8'h10});
    end
  endtask

  task automatic test_reset_mid_read();
    exp_q.delete(); obs_q.delete();
    send(enc_write(3'd3, 8'h5a));
    send(enc_read(3'd3));
    @(negedge clk);
    tests++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL midreset_busy got=%b want=1", busy); end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    exp_q.delete();
    repeat (3) @(negedge clk);
    tests++; if (obs_q.size() != 0) begin errors++; $display("[TB] FAIL midreset_no_pulse got=%0d pulses want=0", obs_q.size()); end
    tests++; if (instr_ready !== 1'b1 || busy !== 1'b0 || alu_op !== NOP) begin
      errors++; $display("[TB] FAIL midreset_idle ready=%b busy=%b op=%0d want 1,0,NOP", instr_ready, busy, alu_op);
    end
    tests++; if (retired_count !== 16'd0) begin errors++; $display("[TB] FAIL midreset_retired got=%h want=0000", retired_count); end
    send(enc_write(3'd4, 8'h77));
    send(enc_read(3'd4));
    send(enc_read(3'd3));
    drain();
    tests++; if (obs_q.size() != 2 || obs_q[0] !== {3'd4, 8'h77} || obs_q[1] !== exp_q[1]) begin
      errors++; $display("[TB] FAIL midreset_after count=%0d got=%h,%h want=%h,%h", obs_q.size(), obs_q[0], obs_q[1], {3'd4, 8'h77}, exp_q[1]);
    end
  endtask

  task automatic test_nop_retire();
    logic [15:0] want;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    model_reset();
    exp_q.delete(); obs_q.delete();
    send({2'b00, 14'h3abc});
    tests++; if (instr_ready !== 1'b1 || alu_op !== NOP || busy !== 1'b0) begin
      errors++; $display("[TB] FAIL nop_no_stall ready=%b op=%0d busy=%b want 1,NOP,0", instr_ready, alu_op, busy);
    end
    send(enc_write(3'd0, 8'h03));
    send(enc_write(3'd1, 8'h04));
    send(enc_add(3'd0, 3'd1, 3'd7));
    send(enc_read(3'd7));
    drain();
`ifdef ALU_SEQ_RETIRE_COUNT_EN
    want = 16'd5;
`else
    want = 16'd0;
`endif
    tests++; if (retired_count !== want) begin errors++; $display("[TB] FAIL retired_five got=%h want=%h", retired_count, want); end
    tests++; if (obs_q.size() != 1 || obs_q[0] !== {3'd7, 8'h07}) begin
      errors++; $display("[TB] FAIL nop_read count=%0d got=%h want=%h", obs_q.size(), obs_q[0], {3'd7, 8'h07});
    end
  endtask

  task automatic test_random();
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 60; i++) send(16'($urandom));
    for (int r = 0; r < 8; r++) send(enc_read(3'(r)));
    drain();
    tests++; if (obs_q.size() != exp_q.size()) begin errors++; $display("[TB] FAIL random_count got=%0d want=%0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      tests++; if (obs_q[i] !== exp_q[i]) begin errors++; $display("[TB] FAIL random_read[%0d] got=%h want=%h", i, obs_q[i], exp_q[i]); end
    end
    tests++; if (retired_count !== expected_retired()) begin
      errors++; $display("[TB] FAIL random_retired got=%h want=%h", retired_count, expected_retired());
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_fibonacci();
    test_timing();
    test_wrap();
    test_reset_mid_read();
    test_nop_retire();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
